bus_arb_5: RTL and testbench

BUS_ARB_5 -- requirements
Module: bus_arb_5

---
 rtl/bus_arb_5.sv | 122 ++++++++++++
 tb/tb_bus_arb_5.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bus_arb_5.sv
// bus_arb_5: five-requester round-robin bus arbiter with hold timeout.
//   clk, rst_n (sync, active-low), req[4:0], done -> gnt[4:0] one-hot,
//   sel[2:0] owner index, busy, timeout (one-cycle forced-release pulse).
module bus_arb_5 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
  input  logic       done,
  output logic [4:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [4:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic       found;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       hit_max;
  logic       normal_rel;

  // Round-robin search starting at ptr, wrapping modulo 5.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      cand = 3'((32'(ptr_q) + k) % 5);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    hit_max    = (cnt_q == CNT_MAX);
    normal_rel = done || !req[sel_q];

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 5'b00001 << pick;
          sel_d   = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (normal_rel || hit_max) begin
          state_d   = IDLE;
          gnt_d     = '0;
          sel_d     = '0;
          busy_d    = 1'b0;
          cnt_d     = '0;
          ptr_d     = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
          // Timeout only when the counter alone forced the release.
          timeout_d = hit_max && !normal_rel;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arb_5.sv
module tb_bus_arb_5;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic       done;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int unsigned n_checks;
  int unsigned n_pass;

  bus_arb_5 #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] g, input logic [2:0] s,
                            input logic b, input logic t);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int unsigned owners [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    req      = '0;
    done     = 1'b0;

    // reset state
    do_reset();
    expect_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0);

    // done in IDLE ignored
    done = 1'b1;
    tick();
    expect_out("idle_done", 5'b00000, 3'd0, 1'b0, 1'b0);
    done = 1'b0;

    // single request
    req = 5'b00100;
    tick();
    expect_out("single.gnt", 5'b00100, 3'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("single.rel", 5'b00000, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = '0;
    tick();

    // fairness from ptr=0
    do_reset();
    req = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_out($sformatf("fair%0d.c1", i), 5'b00001 << owners[i], 3'(owners[i]), 1'b1, 1'b0);
      tick();
      expect_out($sformatf("fair%0d.c2", i), 5'b00001 << owners[i], 3'(owners[i]), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      expect_out($sformatf("fair%0d.idle", i), 5'b00000, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
    end

    // wrap: ptr=1, req 10001 -> owner 4, then owner 0
    req = 5'b10001;
    tick();
    expect_out("wrap.g4", 5'b10000, 3'd4, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("wrap.idle", 5'b00000, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("wrap.g0", 5'b00001, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();

    // timeout with TIMEOUT=4: ptr=1
    req = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("to.hold%0d", i), 5'b00010, 3'd1, 1'b1, 1'b0);
    end
    tick();
    expect_out("to.pulse", 5'b00000, 3'd0, 1'b0, 1'b1);
    tick();
    expect_out("to.regrant", 5'b00010, 3'd1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("to.rel", 5'b00000, 3'd0, 1'b0, 1'b0);
    done = 1'b0;

    // simultaneous done and cnt==TIMEOUT-1: ptr=2, only req[1]
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sim.hold%0d", i), 32'(gnt), 32'h02);
    end
    done = 1'b1;
    tick();
    expect_out("sim.rel", 5'b00000, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("sim.next", 5'b00010, 3'd1, 1'b1, 1'b0);
    req = '0;
    tick();
    expect_out("sim.drop", 5'b00000, 3'd0, 1'b0, 1'b0);

    // reset mid-grant; other req bits ignored during GRANT
    do_reset();
    req = 5'b01000;
    tick();
    expect_out("rmg.g3", 5'b01000, 3'd3, 1'b1, 1'b0);
    req = 5'b11000;
    tick();
    expect_out("rmg.hold", 5'b01000, 3'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    expect_out("rmg.rst", 5'b00000, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_out("rmg.g3b", 5'b01000, 3'd3, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
